// File: rtl/cluster_rate_monitor.sv
// cluster_rate_monitor: windowed cluster-count sum/max/overflow monitor with sticky overflow and burst alarms
module cluster_rate_monitor #(
  parameter int CNT_BITS     = 8,
  parameter int OVF_THRESH   = 8,
  parameter int WINDOW_LOG2  = 12,
  parameter int ACC_BITS     = 20,
  parameter int OVF_CNT_BITS = 16,
  parameter int BURST_LEN    = 4
) (
  input  logic                    clock4x,
  input  logic                    reset,
  input  logic [CNT_BITS-1:0]     cnt_in,
  input  logic                    cnt_valid,
  input  logic                    enable,
  input  logic                    clear_sticky,
  output logic                    win_valid,
  output logic                    win_partial,
  output logic [ACC_BITS-1:0]     win_sum,
  output logic [CNT_BITS-1:0]     win_max,
  output logic [OVF_CNT_BITS-1:0] win_ovf,
  output logic [WINDOW_LOG2:0]    win_samples,
  output logic                    sticky_ovf,
  output logic                    burst_alarm,
  output logic                    busy
);
  localparam int RUN_BITS = $clog2(BURST_LEN + 1);
  localparam logic [WINDOW_LOG2:0] WIN_LEN = {1'b1, {WINDOW_LOG2{1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t                  state_q;
  logic [ACC_BITS-1:0]     sum_q, sum_d;
  logic [CNT_BITS-1:0]     max_q, max_d;
  logic [OVF_CNT_BITS-1:0] ovf_q, ovf_d;
  logic [WINDOW_LOG2:0]    smp_q, smp_d;
  logic [RUN_BITS-1:0]     run_q, run_d;
  logic                    win_valid_q, win_partial_q, sticky_q, burst_q, busy_q;
  logic [ACC_BITS-1:0]     win_sum_q;
  logic [CNT_BITS-1:0]     win_max_q;
  logic [OVF_CNT_BITS-1:0] win_ovf_q;
  logic [WINDOW_LOG2:0]    win_smp_q;
  logic [ACC_BITS:0]       sum_ext;
  logic                    accept, is_ovf, pub_full, pub, burst_hit;
  // Next-window totals assuming the current sample is accepted, and publish decisions
  always_comb begin
    accept    = state_q == RUN && cnt_valid && enable;
    is_ovf    = cnt_in > CNT_BITS'(OVF_THRESH);
    sum_ext   = {1'b0, sum_q} + (ACC_BITS+1)'(cnt_in);
    sum_d     = sum_ext[ACC_BITS] ? '1 : sum_ext[ACC_BITS-1:0];
    max_d     = cnt_in > max_q ? cnt_in : max_q;
    ovf_d     = is_ovf && ovf_q != '1 ? ovf_q + 1'b1 : ovf_q;
    smp_d     = smp_q + 1'b1;
    run_d     = !is_ovf ? '0 : run_q == RUN_BITS'(BURST_LEN) ? run_q : run_q + 1'b1;
    burst_hit = accept && is_ovf && run_d == RUN_BITS'(BURST_LEN);
    pub_full  = accept && smp_d == WIN_LEN;
    pub       = pub_full || (state_q == FLUSH && smp_q != '0);
  end
  // FSM, accumulators, published window registers and alarms
  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sum_q         <= '0;
      max_q         <= '0;
      ovf_q         <= '0;
      smp_q         <= '0;
      run_q         <= '0;
      win_valid_q   <= 1'b0;
      win_partial_q <= 1'b0;
      win_sum_q     <= '0;
      win_max_q     <= '0;
      win_ovf_q     <= '0;
      win_smp_q     <= '0;
      sticky_q      <= 1'b0;
      burst_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_q <= enable ? RUN : IDLE;
        RUN:     state_q <= enable ? RUN : FLUSH;
        default: state_q <= IDLE;
      endcase
      busy_q      <= state_q != IDLE;
      sticky_q    <= (sticky_q && !clear_sticky) || (accept && is_ovf);
      burst_q     <= (burst_q && !clear_sticky) || burst_hit;
      win_valid_q <= pub;
      if (pub) begin
        win_partial_q <= !pub_full;
        win_sum_q     <= pub_full ? sum_d : sum_q;
        win_max_q     <= pub_full ? max_d : max_q;
        win_ovf_q     <= pub_full ? ovf_d : ovf_q;
        win_smp_q     <= pub_full ? smp_d : smp_q;
      end
      if (state_q != RUN || pub_full) begin
        sum_q <= '0;
        max_q <= '0;
        ovf_q <= '0;
        smp_q <= '0;
      end else if (accept) begin
        sum_q <= sum_d;
        max_q <= max_d;
        ovf_q <= ovf_d;
        smp_q <= smp_d;
      end
      if (state_q != RUN) run_q <= '0;
      else if (accept) run_q <= run_d;
    end
  end
  assign win_valid   = win_valid_q;
  assign win_partial = win_partial_q;
  assign win_sum     = win_sum_q;
  assign win_max     = win_max_q;
  assign win_ovf     = win_ovf_q;
  assign win_samples = win_smp_q;
  assign sticky_ovf  = sticky_q;
  assign burst_alarm = burst_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_cluster_rate_monitor.sv
// tb_cluster_rate_monitor: table vectors, hand-written reset sequence and randomized model comparison
module tb_cluster_rate_monitor;
  logic clk, rst, cv, en, clr;
  logic [7:0] cnt;
  logic win_valid, win_partial, sticky_ovf, burst_alarm, busy;
  logic [7:0] win_sum, win_max;
  logic [15:0] win_ovf;
  logic [2:0] win_samples;
  int checks = 0;
  int errors = 0;

  cluster_rate_monitor #(
    .CNT_BITS(8), .OVF_THRESH(8), .WINDOW_LOG2(2), .ACC_BITS(8), .OVF_CNT_BITS(16), .BURST_LEN(3)
  ) dut (
    .clock4x(clk), .reset(rst), .cnt_in(cnt), .cnt_valid(cv), .enable(en), .clear_sticky(clr),
    .win_valid(win_valid), .win_partial(win_partial), .win_sum(win_sum), .win_max(win_max),
    .win_ovf(win_ovf), .win_samples(win_samples), .sticky_ovf(sticky_ovf),
    .burst_alarm(burst_alarm), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    bit cv; int cnt; bit en; bit clr;
    bit v; bit p; int sum; int max; int ovf; int smp; bit st; bit bu; bit by;
  } vec_t;
  vec_t tbl[$];

  // Reference model: keeps the open window as a list of samples and totals it on publish
  int m_state, m_run;
  int m_q[$];
  bit e_v, e_p, e_st, e_bu, e_by;
  int e_sum, e_max, e_ovf, e_smp;

  function automatic void m_reset();
    m_state = 0; m_run = 0; m_q.delete();
    e_v = 0; e_p = 0; e_st = 0; e_bu = 0; e_by = 0;
    e_sum = 0; e_max = 0; e_ovf = 0; e_smp = 0;
  endfunction

  function automatic void m_publish(bit part);
    int s = 0, mx = 0, o = 0;
    foreach (m_q[i]) begin
      s += m_q[i];
      if (m_q[i] > mx) mx = m_q[i];
      if (m_q[i] > 8) o++;
    end
    e_v = 1; e_p = part; e_sum = s > 255 ? 255 : s; e_max = mx; e_ovf = o; e_smp = m_q.size();
  endfunction

  function automatic void m_step(bit c_v, int c, bit c_en, bit c_clr);
    bit acc = m_state == 1 && c_en && c_v;
    bit ov = c > 8;
    e_v = 0;
    e_by = m_state != 0;
    if (acc) m_run = ov ? (m_run < 3 ? m_run + 1 : 3) : 0;
    e_st = (e_st && !c_clr) || (acc && ov);
    e_bu = (e_bu && !c_clr) || (acc && ov && m_run == 3);
    if (m_state == 0) begin
      if (c_en) m_state = 1;
    end else if (m_state == 1) begin
      if (!c_en) m_state = 2;
      else if (acc) begin
        m_q.push_back(c);
        if (m_q.size() == 4) begin
          m_publish(0);
          m_q.delete();
        end
      end
    end else begin
      if (m_q.size() > 0) m_publish(1);
      m_q.delete();
      m_run = 0;
      m_state = 0;
    end
  endfunction

  task automatic cmp(string n, logic [31:0] got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  task automatic chk_all(string t, bit v, bit p, int s, int mx, int o, int n, bit st, bit bu, bit by);
    cmp({t, ".valid"}, 32'(win_valid), int'(v));
    cmp({t, ".partial"}, 32'(win_partial), int'(p));
    cmp({t, ".sum"}, 32'(win_sum), s);
    cmp({t, ".max"}, 32'(win_max), mx);
    cmp({t, ".ovf"}, 32'(win_ovf), o);
    cmp({t, ".samples"}, 32'(win_samples), n);
    cmp({t, ".sticky"}, 32'(sticky_ovf), int'(st));
    cmp({t, ".burst"}, 32'(burst_alarm), int'(bu));
    cmp({t, ".busy"}, 32'(busy), int'(by));
  endtask

  task automatic tick(bit c_v, int c, bit c_en, bit c_clr);
    cv = c_v; cnt = 8'(c); en = c_en; clr = c_clr;
    @(posedge clk);
    m_step(c_v, c, c_en, c_clr);
    @(negedge clk);
  endtask

  function automatic void add(bit a_cv, int a_cnt, bit a_en, bit a_clr, bit v, bit p, int s, int mx,
                              int o, int n, bit st, bit bu, bit by);
    vec_t r;
    r.cv = a_cv; r.cnt = a_cnt; r.en = a_en; r.clr = a_clr;
    r.v = v; r.p = p; r.sum = s; r.max = mx; r.ovf = o; r.smp = n; r.st = st; r.bu = bu; r.by = by;
    tbl.push_back(r);
  endfunction

  initial begin
    rst = 1; cv = 0; cnt = 0; en = 0; clr = 0;
    m_reset();
    // basic window 3,9,0,12
    add(0,0,1,0,   0,0,0,0,0,0,   0,0,0);
    add(1,3,1,0,   0,0,0,0,0,0,   0,0,1);
    add(1,9,1,0,   0,0,0,0,0,0,   1,0,1);
    add(1,0,1,0,   0,0,0,0,0,0,   1,0,1);
    add(1,12,1,0,  1,0,24,12,2,4, 1,0,1);
    add(0,0,1,0,   0,0,24,12,2,4, 1,0,1);
    // back-to-back windows 1..8
    for (int i = 1; i <= 8; i++)
      if (i == 4) add(1,i,1,0, 1,0,10,4,0,4, 1,0,1);
      else if (i == 8) add(1,i,1,0, 1,0,26,8,0,4, 1,0,1);
      else if (i < 4) add(1,i,1,0, 0,0,24,12,2,4, 1,0,1);
      else add(1,i,1,0, 0,0,10,4,0,4, 1,0,1);
    // partial window: three 5s then enable drop (the sample in the drop cycle is ignored)
    for (int i = 0; i < 4; i++) add(1,5,i < 3,0, 0,0,26,8,0,4, 1,0,1);
    add(0,0,0,0,   1,1,15,5,0,3,  1,0,1);
    add(0,0,0,0,   0,1,15,5,0,3,  1,0,0);
    // enable toggled with no samples: no publish
    add(0,0,1,0,   0,1,15,5,0,3,  1,0,0);
    add(0,0,0,0,   0,1,15,5,0,3,  1,0,1);
    add(0,0,0,0,   0,1,15,5,0,3,  1,0,1);
    add(0,0,0,0,   0,1,15,5,0,3,  1,0,0);
    // saturation: four 255s
    add(0,0,1,0,   0,1,15,5,0,3,  1,0,0);
    add(1,255,1,0, 0,1,15,5,0,3,  1,0,1);
    add(1,255,1,0, 0,1,15,5,0,3,  1,0,1);
    add(1,255,1,0, 0,1,15,5,0,3,  1,1,1);
    add(1,255,1,0, 1,0,255,255,4,4, 1,1,1);
    add(0,0,1,1,   0,0,255,255,4,4, 0,0,1);
    // burst: 2,9,9,2 then 9,9,9 with clear on the third 9
    add(1,2,1,0,   0,0,255,255,4,4, 0,0,1);
    add(1,9,1,0,   0,0,255,255,4,4, 1,0,1);
    add(1,9,1,0,   0,0,255,255,4,4, 1,0,1);
    add(1,2,1,0,   1,0,22,9,2,4,    1,0,1);
    add(1,9,1,0,   0,0,22,9,2,4,    1,0,1);
    add(1,9,1,0,   0,0,22,9,2,4,    1,0,1);
    add(1,9,1,1,   0,0,22,9,2,4,    1,1,1);
    add(0,0,1,0,   0,0,22,9,2,4,    1,1,1);

    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 0,0,0,0,0,0, 0,0,0);
    rst = 0;
    foreach (tbl[i]) begin
      tick(tbl[i].cv, tbl[i].cnt, tbl[i].en, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].p, tbl[i].sum, tbl[i].max, tbl[i].ovf,
              tbl[i].smp, tbl[i].st, tbl[i].bu, tbl[i].by);
    end

    // reset mid-window clears everything at once, without a publish
    rst = 1; cv = 0; en = 1;
    #1 chk_all("rst_mid", 0,0,0,0,0,0, 0,0,0);
    m_reset();
    @(negedge clk);
    chk_all("rst_hold", 0,0,0,0,0,0, 0,0,0);
    rst = 0;
    tick(0,0,1,0);
    chk_all("rst_run", 0,0,0,0,0,0, 0,0,0);
    for (int i = 0; i < 3; i++) begin
      tick(1,7,1,0);
      chk_all($sformatf("rst_s%0d", i), 0,0,0,0,0,0, 0,0,1);
    end
    tick(1,7,1,0);
    chk_all("rst_win", 1,0,28,7,0,4, 0,0,1);

    // randomized run against the model
    rst = 1; m_reset();
    @(negedge clk);
    rst = 0;
    begin
      bit r_en = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 499) == 0) begin
          rst = 1;
          m_reset();
          #1 chk_all("rnd_rst", 0,0,0,0,0,0, 0,0,0);
          @(negedge clk);
          rst = 0;
        end
        if ($urandom_range(0, 19) == 0) r_en = !r_en;
        tick($urandom_range(0, 9) < 7,
             $urandom_range(0, 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255)),
             r_en, $urandom_range(0, 29) == 0);
        chk_all("rnd", e_v, e_p, e_sum, e_max, e_ovf, e_smp, e_st, e_bu, e_by);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
